// File: rtl/event_led_stretcher.sv
// rtl/event_led_stretcher.sv - stretches event strobes into visible active-low LED blinks
// with a saturating queue of events that arrive while a blink is in progress.
module event_led_stretcher #(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int ON_CYCLES    = SYSTEM_CLOCK / 20,
    parameter int OFF_CYCLES   = SYSTEM_CLOCK / 20,
    parameter int PEND_W       = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              event_i,
    input  logic              clear_i,
    output logic              led_n_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [PEND_W-1:0]  pending, pending_next;
    logic               overflow, overflow_next;
    logic               led_n, led_n_next;
    logic               busy, busy_next;
    logic               ev_q;
    logic               rise;
    logic               queue_rise;

    assign rise = event_i & ~ev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            timer    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            led_n    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            pending  <= pending_next;
            overflow <= overflow_next;
            led_n    <= led_n_next;
            busy     <= busy_next;
        end
        // Tracking the input during reset keeps a level held across release from counting.
        ev_q <= event_i;
    end

    always_comb begin
        state_next    = state;
        timer_next    = timer;
        pending_next  = pending;
        overflow_next = overflow & ~clear_i;
        queue_rise    = 1'b0;
        case (state)
            IDLE: begin
                // A rise here is either the event being blinked or offsets the dequeue.
                if (rise || (pending != '0)) begin
                    state_next = ON;
                    timer_next = ON_LOAD;
                    if (!rise) begin
                        pending_next = pending - 1'b1;
                    end
                end
            end
            ON: begin
                queue_rise = rise;
                if (timer == '0) begin
                    state_next = OFF;
                    timer_next = OFF_LOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            OFF: begin
                queue_rise = rise;
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (queue_rise) begin
            if (pending == PEND_MAX) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending + 1'b1;
            end
        end
        led_n_next = (state_next != ON);
        busy_next  = (state_next != IDLE);
    end

    always_comb begin
        led_n_o    = led_n;
        busy_o     = busy;
        pending_o  = pending;
        overflow_o = overflow;
    end

endmodule

// File: tb/tb_event_led_stretcher.sv
// tb/tb_event_led_stretcher.sv - scoreboard bench: blink-window reference model feeds a queue
// that a separate monitor drains and compares against the DUT every cycle.
module tb_event_led_stretcher;

    localparam int ON     = 4;
    localparam int OFF    = 3;
    localparam int PW     = 2;
    localparam int PMAX   = (1 << PW) - 1;

    logic          clk_i;
    logic          reset_i;
    logic          event_i;
    logic          clear_i;
    logic          led_n_o;
    logic          busy_o;
    logic [PW-1:0] pending_o;
    logic          overflow_o;

    event_led_stretcher #(
        .SYSTEM_CLOCK(1000),
        .ON_CYCLES   (ON),
        .OFF_CYCLES  (OFF),
        .PEND_W      (PW)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .event_i   (event_i),
        .clear_i   (clear_i),
        .led_n_o   (led_n_o),
        .busy_o    (busy_o),
        .pending_o (pending_o),
        .overflow_o(overflow_o)
    );

    typedef struct {
        logic led_n;
        logic busy;
        int   pend;
        logic ov;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a blink started at clock k owns the LED for clocks k..k+ON-1,
    // keeps the block busy through k+ON+OFF-1, and the next blink may start at k+ON+OFF+1.
    int   m_k     = 0;
    int   m_start = -1000;
    int   m_pend  = 0;
    logic m_ov    = 1'b0;
    logic m_prev  = 1'b0;
    int   blinks  = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input int act, input int req, input int cyc);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic cycle(input logic ev, input logic clr, input logic rst);
        exp_t e;
        logic rise;
        logic ovset;
        @(negedge clk_i);
        event_i = ev;
        clear_i = clr;
        reset_i = rst;
        m_k++;
        if (rst) begin
            m_pend  = 0;
            m_ov    = 1'b0;
            m_start = -1000;
            m_prev  = ev;
        end else begin
            rise   = ev && !m_prev;
            m_prev = ev;
            ovset  = 1'b0;
            if ((m_k >= m_start + ON + OFF + 1) && (rise || m_pend > 0)) begin
                m_start = m_k;
                blinks++;
                if (m_pend > 0) m_pend = m_pend - 1 + int'(rise);
            end else if (rise) begin
                if (m_pend == PMAX) ovset = 1'b1;
                else m_pend++;
            end
            if (ovset) m_ov = 1'b1;
            else if (clr) m_ov = 1'b0;
        end
        e.led_n = !((m_k >= m_start) && (m_k <= m_start + ON - 1));
        e.busy  = (m_k >= m_start) && (m_k <= m_start + ON + OFF - 1);
        e.pend  = m_pend;
        e.ov    = m_ov;
        e.cyc   = m_k;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("led_n_o",    int'(led_n_o),    int'(e.led_n), e.cyc);
                check("busy_o",     int'(busy_o),     int'(e.busy),  e.cyc);
                check("pending_o",  int'(pending_o),  e.pend,        e.cyc);
                check("overflow_o", int'(overflow_o), int'(e.ov),    e.cyc);
            end
        end
    end

    initial begin : stimulus
        int b0;
        int budget;
        reset_i = 1'b1;
        event_i = 1'b1;
        clear_i = 1'b0;
        // Level already high at reset release must not blink.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        b0 = blinks;
        check("no_blink_after_release", b0, 0, m_k);
        // Single pulse.
        pulses(1);
        idle(12);
        // Three pulses two cycles apart.
        b0 = blinks;
        pulses(3);
        idle(30);
        check("three_pulse_blinks", blinks - b0, 3, m_k);
        // Burst that saturates the queue, then clear.
        pulses(6);
        idle(50);
        cycle(1'b0, 1'b1, 1'b0);
        idle(4);
        // Held high is one event.
        b0 = blinks;
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0);
        idle(15);
        check("held_high_blinks", blinks - b0, 1, m_k);
        // Reset during the second ON cycle of a blink with two queued.
        pulses(4);
        idle(1);
        cycle(1'b0, 1'b0, 1'b1);
        b0 = blinks;
        idle(25);
        check("no_blink_after_reset", blinks - b0, 0, m_k);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 40) == 0),
                  logic'($urandom_range(0, 300) == 0));
        end
        idle(30);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        #2;
        check("scoreboard_drained", q.size(), 0, m_k);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
